segre_dcache_ctrl: RTL and testbench

//  Sequencing controller for the data-cache data array. Sits between the core
//  MEM stage and the array, and owns tags/valid bits. Handles load hit/miss

---
 rtl/segre_dcache_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_segre_dcache_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : segre_dcache_ctrl
// Purpose  : Sequencing controller for a direct-mapped data-cache data array.
//            Owns the tag/valid store, serves loads (hit, or miss with a full
//            lane refill from the MMU followed by a replayed lookup) and
//            stores (write-through, no-write-allocate). Drives the array's
//            read / core-write / refill-write strobes with index, byte
//            address and data.
// Ports    : clk_i, rsn_i                 clock, synchronous active-low reset
//            core_req_* / core_rsp_*      MEM-stage request and response
//            mmu_*                        lane refill and write-through path
//            dc_*                         data-array strobes, address, data
//            hit_cnt_o, miss_cnt_o        lookup statistics
// Types    : memop type encoding BYTE=2'd0, HALF=2'd1, WORD=2'd2
//            (2'd3 is answered with an error response).
// Config   : DCACHE_STATS_EN - when defined, hit_cnt_o/miss_cnt_o count
//            first-pass lookups (saturating). When undefined both read 0.
// Revision : 1.0  initial release
// ============================================================================
module segre_dcache_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int LANE_BITS = 128,
  parameter int NUM_LANES = 4
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         core_req_valid_i,
  output logic                         core_req_ready_o,
  input  logic                         core_req_we_i,
  input  logic [1:0]                   core_req_type_i,
  input  logic [ADDR_W-1:0]            core_req_addr_i,
  input  logic [ADDR_W-1:0]            core_req_data_i,
  output logic                         core_rsp_valid_o,
  output logic [ADDR_W-1:0]            core_rsp_data_o,
  output logic                         core_rsp_err_o,
  output logic                         mmu_rd_req_o,
  output logic                         mmu_wr_req_o,
  output logic [ADDR_W-1:0]            mmu_addr_o,
  output logic [ADDR_W-1:0]            mmu_wr_data_o,
  output logic [1:0]                   mmu_wr_type_o,
  input  logic                         mmu_ack_i,
  input  logic [LANE_BITS-1:0]         mmu_data_i,
  output logic                         dc_rd_data_o,
  output logic                         dc_wr_data_o,
  output logic                         dc_mmu_wr_data_o,
  output logic [ADDR_W-1:0]            dc_addr_o,
  output logic [$clog2(NUM_LANES)-1:0] dc_index_o,
  output logic [1:0]                   dc_type_o,
  output logic [ADDR_W-1:0]            dc_data_o,
  output logic [LANE_BITS-1:0]         dc_mmu_data_o,
  input  logic [ADDR_W-1:0]            dc_data_i,
  output logic [31:0]                  hit_cnt_o,
  output logic [31:0]                  miss_cnt_o
);

  localparam int BYTE_W = $clog2(LANE_BITS / 8);
  localparam int IDX_W  = $clog2(NUM_LANES);
  localparam int TAG_W  = ADDR_W - IDX_W - BYTE_W;

  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;
  localparam logic [1:0] MEM_BAD  = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    MISS    = 3'd2,
    WTHRU   = 3'd3,
    RESPOND = 3'd4
  } state_e;

  state_e state, state_nxt;

  // Request latched at accept and held for the whole transaction.
  logic              req_we;
  logic [1:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_data;

  logic rsp_err, rsp_err_nxt;

  // High for the single MISS cycle after the refill write. The array write is
  // registered, so the replayed lookup is held off one cycle to read the new
  // lane rather than racing it.
  logic refilled;
  logic lane_fill;

  logic [TAG_W-1:0]     tags [NUM_LANES];
  logic [NUM_LANES-1:0] valid;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [ADDR_W-1:0] lane_addr;
  logic              hit;
  logic              misaligned;

  assign idx        = req_addr[IDX_W+BYTE_W-1:BYTE_W];
  assign tag        = req_addr[ADDR_W-1:IDX_W+BYTE_W];
  assign lane_addr  = {req_addr[ADDR_W-1:BYTE_W], {BYTE_W{1'b0}}};
  assign hit        = valid[idx] && (tags[idx] == tag);
  // Aligned accesses can never straddle a lane, so alignment alone covers
  // the lane-crossing case.
  assign misaligned = ((req_type == MEM_HALF) && req_addr[0])
                   || ((req_type == MEM_WORD) && (req_addr[1:0] != 2'b00))
                   || (req_type == MEM_BAD);

  always_comb begin
    state_nxt        = state;
    rsp_err_nxt      = rsp_err;
    lane_fill        = 1'b0;
    core_req_ready_o = 1'b0;
    core_rsp_valid_o = 1'b0;
    core_rsp_data_o  = '0;
    core_rsp_err_o   = 1'b0;
    mmu_rd_req_o     = 1'b0;
    mmu_wr_req_o     = 1'b0;
    mmu_addr_o       = '0;
    mmu_wr_data_o    = '0;
    mmu_wr_type_o    = '0;
    dc_rd_data_o     = 1'b0;
    dc_wr_data_o     = 1'b0;
    dc_mmu_wr_data_o = 1'b0;
    dc_addr_o        = '0;
    dc_index_o       = '0;
    dc_type_o        = '0;
    dc_data_o        = '0;
    dc_mmu_data_o    = '0;

    case (state)
      IDLE: begin
        core_req_ready_o = 1'b1;
        if (core_req_valid_i) begin
          state_nxt   = LOOKUP;
          rsp_err_nxt = 1'b0;
        end
      end

      LOOKUP: begin
        if (misaligned) begin
          rsp_err_nxt = 1'b1;
          state_nxt   = RESPOND;
        end else if (!req_we) begin
          if (hit) begin
            dc_rd_data_o = 1'b1;
            dc_addr_o    = req_addr;
            dc_index_o   = idx;
            dc_type_o    = req_type;
            state_nxt    = RESPOND;
          end else begin
            state_nxt = MISS;
          end
        end else begin
          // No-write-allocate: only a resident lane is updated.
          if (hit) begin
            dc_wr_data_o = 1'b1;
            dc_addr_o    = req_addr;
            dc_index_o   = idx;
            dc_type_o    = req_type;
            dc_data_o    = req_data;
          end
          state_nxt = WTHRU;
        end
      end

      MISS: begin
        if (!refilled) begin
          mmu_rd_req_o = 1'b1;
          mmu_addr_o   = lane_addr;
          if (mmu_ack_i) begin
            dc_mmu_wr_data_o = 1'b1;
            dc_mmu_data_o    = mmu_data_i;
            dc_addr_o        = lane_addr;
            dc_index_o       = idx;
            lane_fill        = 1'b1;
          end
        end else begin
          state_nxt = LOOKUP;
        end
      end

      WTHRU: begin
        mmu_wr_req_o  = 1'b1;
        mmu_addr_o    = req_addr;
        mmu_wr_data_o = req_data;
        mmu_wr_type_o = req_type;
        if (mmu_ack_i) begin
          state_nxt = RESPOND;
        end
      end

      RESPOND: begin
        core_rsp_valid_o = 1'b1;
        core_rsp_err_o   = rsp_err;
        // The array read issued in LOOKUP lands on dc_data_i this cycle.
        if (!req_we && !rsp_err) begin
          core_rsp_data_o = dc_data_i;
        end
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state    <= IDLE;
      rsp_err  <= 1'b0;
      refilled <= 1'b0;
      valid    <= '0;
      req_we   <= 1'b0;
      req_type <= '0;
      req_addr <= '0;
      req_data <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        tags[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      rsp_err  <= rsp_err_nxt;
      refilled <= lane_fill;
      if ((state == IDLE) && core_req_valid_i) begin
        req_we   <= core_req_we_i;
        req_type <= core_req_type_i;
        req_addr <= core_req_addr_i;
        req_data <= core_req_data_i;
      end
      if (lane_fill) begin
        valid[idx] <= 1'b1;
        tags[idx]  <= tag;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // Set while the current LOOKUP is the post-refill replay, which must not
  // be counted a second time.
  logic        replay;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      replay   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((state == MISS) && refilled) begin
        replay <= 1'b1;
      end else if (state == LOOKUP) begin
        replay <= 1'b0;
      end
      if ((state == LOOKUP) && !replay && !misaligned) begin
        if (hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_segre_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_segre_dcache_ctrl
// Purpose  : Self-checking bench for segre_dcache_ctrl. Provides a data-array
//            model, an MMU backing store, and a cache reference model kept at
//            the level of "which lane is resident, what memory holds".
// Revision : 1.0  initial release
// ============================================================================
module tb_segre_dcache_ctrl;

  localparam logic [1:0] T_BYTE = 2'd0;
  localparam logic [1:0] T_HALF = 2'd1;
  localparam logic [1:0] T_WORD = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rsn;
  logic         req_valid, req_we;
  logic [1:0]   req_type;
  logic [31:0]  req_addr, req_data;
  logic         ready, rsp_valid, rsp_err;
  logic [31:0]  rsp_data;
  logic         mmu_rd_req, mmu_wr_req, mmu_ack;
  logic [31:0]  mmu_addr, mmu_wr_data;
  logic [1:0]   mmu_wr_type;
  logic [127:0] mmu_data;
  logic         dc_rd, dc_wr, dc_mmu_wr;
  logic [31:0]  dc_addr, dc_wdata, dc_rdata;
  logic [1:0]   dc_index, dc_type;
  logic [127:0] dc_mmu_data;
  logic [31:0]  hit_cnt, miss_cnt;

  segre_dcache_ctrl dut (
    .clk_i(clk), .rsn_i(rsn),
    .core_req_valid_i(req_valid), .core_req_ready_o(ready), .core_req_we_i(req_we),
    .core_req_type_i(req_type), .core_req_addr_i(req_addr), .core_req_data_i(req_data),
    .core_rsp_valid_o(rsp_valid), .core_rsp_data_o(rsp_data), .core_rsp_err_o(rsp_err),
    .mmu_rd_req_o(mmu_rd_req), .mmu_wr_req_o(mmu_wr_req), .mmu_addr_o(mmu_addr),
    .mmu_wr_data_o(mmu_wr_data), .mmu_wr_type_o(mmu_wr_type), .mmu_ack_i(mmu_ack),
    .mmu_data_i(mmu_data),
    .dc_rd_data_o(dc_rd), .dc_wr_data_o(dc_wr), .dc_mmu_wr_data_o(dc_mmu_wr),
    .dc_addr_o(dc_addr), .dc_index_o(dc_index), .dc_type_o(dc_type), .dc_data_o(dc_wdata),
    .dc_mmu_data_o(dc_mmu_data), .dc_data_i(dc_rdata),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  int tests  = 0;
  int failed = 0;

  function automatic int nbytes(input logic [1:0] ty);
    if (ty == T_WORD) return 4;
    if (ty == T_HALF) return 2;
    return 1;
  endfunction

  // ---------------- data array (environment) ----------------
  logic [127:0] arr [4];
  logic [31:0]  arr_q = '0;
  assign dc_rdata = arr_q;

  always @(posedge clk) begin
    logic [127:0] l;
    logic [31:0]  r;
    logic [3:0]   ob;
    l = arr[dc_index];
    r = '0;
    if (dc_mmu_wr) arr[dc_index] <= dc_mmu_data;
    if (dc_wr) begin
      for (int b = 0; b < nbytes(dc_type); b++) begin
        ob = dc_addr[3:0] + 4'(b);
        l[ob*8 +: 8] = dc_wdata[b*8 +: 8];
      end
      arr[dc_index] <= l;
    end
    if (dc_rd) begin
      for (int b = 0; b < nbytes(dc_type); b++) begin
        ob = dc_addr[3:0] + 4'(b);
        r[b*8 +: 8] = l[ob*8 +: 8];
      end
      arr_q <= r;
    end
  end

  // ---------------- MMU backing store and reference model ----------------
  logic [7:0] mem     [8192];
  logic [7:0] ref_mem [8192];
  bit         ref_valid [4];
  int         ref_tag   [4];
  int         ref_hits;
  int         ref_misses;

  typedef struct {
    logic        err;
    logic        hit;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          rsp_win;
    logic [31:0] data;
    logic        err;
    int          n_rd_req, n_wr_req, ack_win;
    int          n_dc_rd, n_dc_wr, n_dc_mmu;
    logic        addr_ok, ready_ok, extra_rsp;
  } obs_t;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  // Cache semantics: a load returns memory contents (zero-extended), a miss
  // makes its lane resident, stores update memory and never allocate.
  task automatic model(input logic we, input logic [1:0] ty, input logic [31:0] a,
                       input logic [31:0] d, output exp_t e);
    int idx, tg;
    idx    = int'(a / 16) % 4;
    tg     = int'(a / 64);
    e.err  = (ty == T_HALF && a % 2 != 0) || (ty == T_WORD && a % 4 != 0);
    e.hit  = !e.err && ref_valid[idx] && (ref_tag[idx] == tg);
    e.data = '0;
    if (!e.err) begin
      if (e.hit) ref_hits++;
      else       ref_misses++;
      if (!we) begin
        for (int b = 0; b < nbytes(ty); b++) e.data[b*8 +: 8] = ref_mem[(int'(a) + b) % 8192];
        if (!e.hit) begin
          ref_valid[idx] = 1'b1;
          ref_tag[idx]   = tg;
        end
      end else begin
        for (int b = 0; b < nbytes(ty); b++) ref_mem[(int'(a) + b) % 8192] = d[b*8 +: 8];
      end
    end
  endtask

  // Drives one request, plays the MMU (ack after dly request cycles, optional
  // spurious acks), and records what the controller did window by window.
  // Window 0 is the accept cycle.
  task automatic do_access(input logic we, input logic [1:0] ty, input logic [31:0] a,
                           input logic [31:0] d, input int dly, input bit spur,
                           output obs_t o);
    int reqs;
    int base;
    reqs = 0;
    o.rsp_win = -1; o.data = '0; o.err = 1'b0; o.ack_win = -1;
    o.n_rd_req = 0; o.n_wr_req = 0; o.n_dc_rd = 0; o.n_dc_wr = 0; o.n_dc_mmu = 0;
    o.addr_ok = 1'b1; o.ready_ok = 1'b0; o.extra_rsp = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_type = ty; req_addr = a; req_data = d;
    #1;
    o.ready_ok = ready;
    for (int w = 1; w <= 100 && o.rsp_win < 0; w++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mmu_ack   = 1'b0;
      if (mmu_rd_req || mmu_wr_req) begin
        reqs++;
        if (mmu_rd_req) begin
          o.n_rd_req++;
          if (mmu_addr !== {a[31:4], 4'h0}) o.addr_ok = 1'b0;
        end
        if (mmu_wr_req) begin
          o.n_wr_req++;
          if ({mmu_addr, mmu_wr_data, mmu_wr_type} !== {a, d, ty}) o.addr_ok = 1'b0;
        end
        if (reqs > dly) begin
          mmu_ack   = 1'b1;
          o.ack_win = w;
          reqs      = 0;
          base      = int'(mmu_addr & 32'h1FF0);
          for (int b = 0; b < 16; b++) mmu_data[b*8 +: 8] = mem[base + b];
          if (mmu_wr_req)
            for (int b = 0; b < nbytes(mmu_wr_type); b++)
              mem[(int'(mmu_addr) + b) % 8192] = mmu_wr_data[b*8 +: 8];
        end
      end else if (spur && $urandom_range(0, 1) == 1) begin
        mmu_ack  = 1'b1;
        mmu_data = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      o.n_dc_rd  += int'(dc_rd);
      o.n_dc_wr  += int'(dc_wr);
      o.n_dc_mmu += int'(dc_mmu_wr);
      if (rsp_valid) begin
        o.rsp_win = w;
        o.data    = rsp_data;
        o.err     = rsp_err;
      end
    end
    @(negedge clk);
    mmu_ack = 1'b0;
    #1;
    o.extra_rsp = rsp_valid | !ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rsn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({ready, rsp_valid, rsp_data, rsp_err, mmu_rd_req, mmu_wr_req, mmu_addr, mmu_wr_data,
         mmu_wr_type, dc_rd, dc_wr, dc_mmu_wr, dc_addr, dc_index, dc_type, dc_wdata, dc_mmu_data}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'h0, 3'b000, 32'h0, 2'h0, 2'h0,
             32'h0, 128'h0}) begin
      failed++;
      $display("FAIL reset_outputs: ready=%b rsp_valid=%b mmu_rd=%b mmu_wr=%b strobes=%b%b%b, want ready=1 rest 0",
               ready, rsp_valid, mmu_rd_req, mmu_wr_req, dc_rd, dc_wr, dc_mmu_wr);
    end
    tests++;
    if ({hit_cnt, miss_cnt} !== 64'h0) begin
      failed++;
      $display("FAIL reset_counters: got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt);
    end
    rsn = 1'b1;
    model_reset();
  endtask

  task automatic test_load_miss();
    obs_t o;
    exp_t e;
    mem[64] = 8'hAA; mem[65] = 8'hBB; mem[66] = 8'hCC; mem[67] = 8'hDD;
    ref_mem[64] = 8'hAA; ref_mem[65] = 8'hBB; ref_mem[66] = 8'hCC; ref_mem[67] = 8'hDD;
    model(1'b0, T_WORD, 32'h40, 32'h0, e);
    do_access(1'b0, T_WORD, 32'h40, 32'h0, 2, 1'b0, o);
    tests++;
    if (o.data !== 32'hDDCCBBAA) begin
      failed++; $display("FAIL miss_data: got %h want ddccbbaa", o.data);
    end
    tests++;
    if (o.rsp_win !== o.ack_win + 3 || o.ack_win < 0) begin
      failed++; $display("FAIL miss_latency: rsp window %0d ack window %0d, want ack+3", o.rsp_win, o.ack_win);
    end
    tests++;
    if ({o.n_rd_req > 0, o.addr_ok, o.n_dc_mmu == 1, o.n_wr_req == 0} !== 4'b1111) begin
      failed++; $display("FAIL miss_mmu_req: rd_req=%0d addr_ok=%b refill_strobes=%0d wr_req=%0d, want >0/1/1/0",
                         o.n_rd_req, o.addr_ok, o.n_dc_mmu, o.n_wr_req);
    end
  endtask

  task automatic test_load_hit();
    obs_t o;
    exp_t e;
    model(1'b0, T_WORD, 32'h40, 32'h0, e);
    do_access(1'b0, T_WORD, 32'h40, 32'h0, 0, 1'b0, o);
    tests++;
    if ({o.rsp_win, o.data} !== {32'd2, 32'hDDCCBBAA}) begin
      failed++; $display("FAIL hit_rsp: window %0d data %h, want 2 ddccbbaa", o.rsp_win, o.data);
    end
    tests++;
    if ({o.n_rd_req == 0, o.n_dc_rd == 1, o.n_dc_mmu == 0} !== 3'b111) begin
      failed++; $display("FAIL hit_traffic: rd_req=%0d rd_strobes=%0d refills=%0d, want 0/1/0",
                         o.n_rd_req, o.n_dc_rd, o.n_dc_mmu);
    end
`ifdef DCACHE_STATS_EN
    tests++;
    if ({hit_cnt, miss_cnt} !== {32'd1, 32'd1}) begin
      failed++; $display("FAIL hit_stats: hit=%0d miss=%0d want 1/1", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_store_hit();
    obs_t o;
    exp_t e;
    model(1'b1, T_WORD, 32'h44, 32'h12345678, e);
    do_access(1'b1, T_WORD, 32'h44, 32'h12345678, 3, 1'b0, o);
    tests++;
    if ({o.n_dc_wr == 1, o.n_wr_req == 4, o.addr_ok, o.n_dc_rd == 0, o.n_dc_mmu == 0} !== 5'b11111) begin
      failed++; $display("FAIL store_hit_traffic: wr_strobes=%0d wr_req=%0d addr_ok=%b, want 1/4/1",
                         o.n_dc_wr, o.n_wr_req, o.addr_ok);
    end
    tests++;
    if (o.rsp_win !== o.ack_win + 1 || o.ack_win < 0 || o.data !== 32'h0) begin
      failed++; $display("FAIL store_rsp: window %0d ack %0d data %h, want ack+1 and 0", o.rsp_win, o.ack_win, o.data);
    end
    model(1'b0, T_WORD, 32'h44, 32'h0, e);
    do_access(1'b0, T_WORD, 32'h44, 32'h0, 0, 1'b0, o);
    tests++;
    if ({o.rsp_win, o.data} !== {32'd2, 32'h12345678}) begin
      failed++; $display("FAIL store_readback: window %0d data %h, want 2 12345678", o.rsp_win, o.data);
    end
  endtask

  task automatic test_store_miss();
    obs_t o;
    exp_t e;
    model(1'b1, T_BYTE, 32'h1000, 32'h000000A5, e);
    do_access(1'b1, T_BYTE, 32'h1000, 32'h000000A5, 1, 1'b0, o);
    tests++;
    if ({o.n_dc_rd, o.n_dc_wr, o.n_dc_mmu, o.n_rd_req} !== 128'h0 || o.n_wr_req == 0 || !o.addr_ok) begin
      failed++; $display("FAIL store_miss_traffic: strobes %0d/%0d/%0d rd_req=%0d wr_req=%0d, want 0/0/0 0 >0",
                         o.n_dc_rd, o.n_dc_wr, o.n_dc_mmu, o.n_rd_req, o.n_wr_req);
    end
    model(1'b0, T_WORD, 32'h1000, 32'h0, e);
    do_access(1'b0, T_WORD, 32'h1000, 32'h0, 0, 1'b0, o);
    tests++;
    if (o.n_rd_req == 0 || o.data !== e.data || o.data[7:0] !== 8'hA5) begin
      failed++; $display("FAIL store_miss_reload: rd_req=%0d data %h, want miss and %h", o.n_rd_req, o.data, e.data);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    exp_t e;
    model(1'b0, T_HALF, 32'h41, 32'h0, e);
    do_access(1'b0, T_HALF, 32'h41, 32'h0, 0, 1'b1, o);
    tests++;
    if ({o.rsp_win, o.err, o.data} !== {32'd2, 1'b1, 32'h0}) begin
      failed++; $display("FAIL misaligned_rsp: window %0d err %b data %h, want 2 1 0", o.rsp_win, o.err, o.data);
    end
    tests++;
    if ({o.n_dc_rd, o.n_dc_wr, o.n_dc_mmu, o.n_rd_req, o.n_wr_req} !== 160'h0) begin
      failed++; $display("FAIL misaligned_traffic: strobes %0d/%0d/%0d reqs %0d/%0d, want all 0",
                         o.n_dc_rd, o.n_dc_wr, o.n_dc_mmu, o.n_rd_req, o.n_wr_req);
    end
  endtask

  task automatic test_reset_mid_miss();
    obs_t o;
    exp_t e;
    int   guard;
    int   stray;
    guard = 0;
    stray = 0;
    // Evict 0x40 so the next load is a guaranteed miss.
    model(1'b0, T_WORD, 32'h140, 32'h0, e);
    do_access(1'b0, T_WORD, 32'h140, 32'h0, 0, 1'b0, o);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_type = T_WORD; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    while (!mmu_rd_req && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (mmu_rd_req !== 1'b1) begin
      failed++; $display("FAIL midreset_reach_miss: mmu_rd_req=%b want 1", mmu_rd_req);
    end
    rsn = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if ({ready, rsp_valid, mmu_rd_req} !== 3'b100) begin
      failed++; $display("FAIL midreset_abort: ready/rsp/rd_req=%b%b%b want 100", ready, rsp_valid, mmu_rd_req);
    end
    rsn = 1'b1;
    model_reset();
    repeat (5) begin
      @(negedge clk);
      #1;
      stray += int'(rsp_valid);
    end
    tests++;
    if (stray !== 0) begin
      failed++; $display("FAIL midreset_no_rsp: got %0d responses want 0", stray);
    end
    model(1'b0, T_WORD, 32'h40, 32'h0, e);
    do_access(1'b0, T_WORD, 32'h40, 32'h0, 1, 1'b0, o);
    tests++;
    if (o.n_rd_req == 0 || o.data !== e.data) begin
      failed++; $display("FAIL midreset_reload: rd_req=%0d data %h, want miss and %h", o.n_rd_req, o.data, e.data);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic        we;
    logic [1:0]  ty;
    logic [31:0] a, d;
    int          tg_pick [4];
    int          exp_win;
    logic [9:0]  sig, exp_sig;
    tg_pick = '{0, 1, 2, 127};
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      ty = 2'($urandom_range(0, 2));
      a  = 32'(tg_pick[$urandom_range(0, 3)] * 64 + $urandom_range(0, 3) * 16);
      a  = a + 32'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3) * 4);
      d  = $urandom;
      model(we, ty, a, d, e);
      do_access(we, ty, a, d, $urandom_range(0, 3), 1'b1, o);
      if (e.err || (!we && e.hit)) exp_win = 2;
      else if (!we)                exp_win = o.ack_win + 3;
      else                         exp_win = o.ack_win + 1;
      tests++;
      if (o.rsp_win !== exp_win || (!e.err && !(!we && e.hit) && o.ack_win < 0)) begin
        failed++; $display("FAIL rand%0d_latency: window %0d want %0d (we=%b ty=%0d a=%h)", n, o.rsp_win, exp_win, we, ty, a);
      end
      tests++;
      if ({o.err, o.data} !== {e.err, e.data}) begin
        failed++; $display("FAIL rand%0d_rsp: err %b data %h want err %b data %h (we=%b ty=%0d a=%h)",
                           n, o.err, o.data, e.err, e.data, we, ty, a);
      end
      sig     = {o.n_rd_req > 0, o.n_wr_req > 0, 2'(o.n_dc_rd), 2'(o.n_dc_wr), 2'(o.n_dc_mmu),
                 o.addr_ok & o.ready_ok, o.extra_rsp};
      exp_sig = {!e.err && !we && !e.hit, !e.err && we, 2'(!e.err && !we), 2'(!e.err && we && e.hit),
                 2'(!e.err && !we && !e.hit), 1'b1, 1'b0};
      tests++;
      if (sig !== exp_sig) begin
        failed++; $display("FAIL rand%0d_traffic: got %b want %b (we=%b ty=%0d a=%h)", n, sig, exp_sig, we, ty, a);
      end
    end
  endtask

  task automatic test_stats();
    logic [31:0] eh, em;
`ifdef DCACHE_STATS_EN
    eh = 32'(ref_hits);
    em = 32'(ref_misses);
`else
    eh = 32'h0;
    em = 32'h0;
`endif
    tests++;
    if ({hit_cnt, miss_cnt} !== {eh, em}) begin
      failed++; $display("FAIL stats_final: hit=%0d miss=%0d want %0d/%0d", hit_cnt, miss_cnt, eh, em);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_type = '0; req_addr = '0; req_data = '0;
    mmu_ack = 1'b0; mmu_data = '0; rsn = 1'b0;
    for (int i = 0; i < 8192; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_store_miss();
    test_misaligned();
    test_reset_mid_miss();
    test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
